// File: rtl/dica_ckpt_engine_pkg.sv
// DiCA checkpoint engine shared constants, states and address helper.
// The dirty-block tracker imports the same definitions.
package dica_ckpt_engine_pkg;

  localparam logic [15:0] DMEM_BASE    = 16'h0200;
  localparam int          DMEM_SIZE    = 1024;
  localparam int          BLK_SIZE     = 64;
  localparam logic [15:0] NVM_BASE     = 16'hA000;
  localparam int          TOTAL_BLOCKS = DMEM_SIZE / BLK_SIZE;
  localparam int          WPB          = BLK_SIZE / 2;
  localparam int          IDX_W        = $clog2(TOTAL_BLOCKS);
  localparam int          W_W          = $clog2(WPB);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_CLR,
    ST_FIN
  } state_e;

  // Byte address of word w of block idx in a region at base (16-bit wrap).
  function automatic logic [15:0] blk_addr(
    input logic [15:0]      base,
    input logic [IDX_W-1:0] idx,
    input logic [W_W-1:0]   w
  );
    logic [15:0] blk_off;
    logic [15:0] wrd_off;
    blk_off = 16'(idx) * 16'(BLK_SIZE);
    wrd_off = 16'({w, 1'b0});
    return base + blk_off + wrd_off;
  endfunction

endpackage

// File: rtl/dica_ckpt_engine_if.sv
// Bundle of tracker, DMEM, NVM and ISR-status signals of the engine.
// master = engine side, slave = surrounding system.
interface dica_ckpt_engine_if;
  import dica_ckpt_engine_pkg::*;

  logic                    start;
  logic [TOTAL_BLOCKS-1:0] d_table;
  logic                    dmem_rd_en;
  logic [15:0]             dmem_addr;
  logic [15:0]             dmem_rd_data;
  logic                    nvm_wr_req;
  logic [15:0]             nvm_addr;
  logic [15:0]             nvm_wr_data;
  logic                    nvm_wr_ack;
  logic                    clr_valid;
  logic [IDX_W-1:0]        clr_idx;
  logic                    busy;
  logic                    done;
  logic [IDX_W:0]          blk_count;

  modport master (
    input  start, d_table, dmem_rd_data, nvm_wr_ack,
    output dmem_rd_en, dmem_addr, nvm_wr_req, nvm_addr,
    output nvm_wr_data, clr_valid, clr_idx,
    output busy, done, blk_count
  );

  modport slave (
    output start, d_table, dmem_rd_data, nvm_wr_ack,
    input  dmem_rd_en, dmem_addr, nvm_wr_req, nvm_addr,
    input  nvm_wr_data, clr_valid, clr_idx,
    input  busy, done, blk_count
  );

endinterface

// File: rtl/dica_ckpt_engine_first_set.sv
// Lowest-set-bit priority encoder.
// idx is 0 when no bit is set; any flags a non-empty vector.
module dica_first_set #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dica_ckpt_engine.sv
// DiCA checkpoint engine: copies dirty DMEM blocks to NVM,
// clears each block in the tracker, then pulses done.
module dica_ckpt_engine
  import dica_ckpt_engine_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  dica_ckpt_engine_if.master  bus
);

  if (int'(NVM_BASE) + DMEM_SIZE - 1 > 32'hFFFF) begin : g_nvm_chk
    $error("checkpoint image overruns the 16-bit address space");
  end
  if (BLK_SIZE < 2 || (BLK_SIZE & (BLK_SIZE - 1)) != 0) begin : g_blk_chk
    $error("BLK_SIZE must be a power of two, at least 2");
  end

  state_e                  state_q;
  logic [TOTAL_BLOCKS-1:0] snap_q;
  logic [IDX_W-1:0]        cur_q;
  logic [W_W-1:0]          w_q;
  logic                    start_q;
  logic                    rd_en_q;
  logic [15:0]             dmem_addr_q;
  logic                    req_q;
  logic [15:0]             nvm_addr_q;
  logic [15:0]             wdata_q;
  logic                    clr_valid_q;
  logic [IDX_W-1:0]        clr_idx_q;
  logic                    busy_q;
  logic                    done_q;
  logic [IDX_W:0]          blk_count_q;

  logic [IDX_W-1:0]        fs_idx;
  logic                    fs_any;

  dica_first_set #(
    .N (TOTAL_BLOCKS),
    .W (IDX_W)
  ) u_first_set (
    .vec (snap_q),
    .idx (fs_idx),
    .any (fs_any)
  );

  assign bus.dmem_rd_en  = rd_en_q;
  assign bus.dmem_addr   = dmem_addr_q;
  assign bus.nvm_wr_req  = req_q;
  assign bus.nvm_addr    = nvm_addr_q;
  assign bus.nvm_wr_data = wdata_q;
  assign bus.clr_valid   = clr_valid_q;
  assign bus.clr_idx     = clr_idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.blk_count   = blk_count_q;

  // Control FSM; every output is registered so it is set on state entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      cur_q       <= '0;
      w_q         <= '0;
      start_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      dmem_addr_q <= '0;
      req_q       <= 1'b0;
      nvm_addr_q  <= '0;
      wdata_q     <= '0;
      clr_valid_q <= 1'b0;
      clr_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      blk_count_q <= '0;
    end else begin
      start_q <= bus.start;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !start_q) begin
            snap_q      <= bus.d_table;
            blk_count_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!fs_any) begin
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            cur_q       <= fs_idx;
            w_q         <= '0;
            rd_en_q     <= 1'b1;
            dmem_addr_q <= blk_addr(DMEM_BASE, fs_idx, '0);
            state_q     <= ST_RD;
          end
        end
        ST_RD: begin
          rd_en_q <= 1'b0;
          state_q <= ST_CAP;
        end
        ST_CAP: begin
          wdata_q    <= bus.dmem_rd_data;
          nvm_addr_q <= blk_addr(NVM_BASE, cur_q, w_q);
          req_q      <= 1'b1;
          state_q    <= ST_WR;
        end
        ST_WR: begin
          if (bus.nvm_wr_ack) begin
            req_q <= 1'b0;
            if (w_q == W_W'(WPB - 1)) begin
              clr_valid_q <= 1'b1;
              clr_idx_q   <= cur_q;
              state_q     <= ST_CLR;
            end else begin
              w_q         <= w_q + 1'b1;
              rd_en_q     <= 1'b1;
              dmem_addr_q <= blk_addr(DMEM_BASE, cur_q, w_q + 1'b1);
              state_q     <= ST_RD;
            end
          end
        end
        ST_CLR: begin
          clr_valid_q   <= 1'b0;
          snap_q[cur_q] <= 1'b0;
          blk_count_q   <= blk_count_q + 1'b1;
          state_q       <= ST_SCAN;
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dica_ckpt_engine.md
Name: dica_ckpt_engine

Overview:
- Consumer side of the DiCA dirty-block tracker.
- On a checkpoint request it snapshots the dirty-block bitmap and walks the set bits lowest index first.
- For each dirty DMEM block it reads every word and writes it to the matching offset of an NVM checkpoint region, then strobes a per-block clear back to the tracker.
- Signals completion to the checkpoint ISR. Sits between the tracker, the DMEM read port and the NVM write port.

Parameters:
- DMEM_BASE, 16'h0200, byte address of DMEM start.
- DMEM_SIZE, 1024, DMEM bytes.
- BLK_SIZE, 64, bytes per tracked block; power of 2, at least 2.
- NVM_BASE, 16'hA000, byte address of the checkpoint image in NVM.
- TOTAL_BLOCKS, DMEM_SIZE/BLK_SIZE (16), bitmap width.
- WPB, BLK_SIZE/2 (32), 16-bit words per block.
- IDX_W, clog2(TOTAL_BLOCKS) (4), block-index width.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: checkpoint request (irq_chkpnt level); rising edge triggers.
- d_table, in, TOTAL_BLOCKS: dirty bitmap from tracker.
- dmem_rd_en, out, 1: DMEM read strobe.
- dmem_addr, out, 16: DMEM byte address.
- dmem_rd_data, in, 16: read data, valid exactly 1 cycle after dmem_rd_en.
- nvm_wr_req, out, 1: NVM write request.
- nvm_addr, out, 16: NVM byte address.
- nvm_wr_data, out, 16: NVM write data.
- nvm_wr_ack, in, 1: NVM accepted the write.
- clr_valid, out, 1: one-cycle pulse; clear dirty bit clr_idx.
- clr_idx, out, IDX_W: block to clear.
- busy, out, 1: engine active.
- done, out, 1: one-cycle completion pulse.
- blk_count, out, IDX_W+1: blocks saved in the last run.

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE. All outputs 0; snapshot, word counter and start-edge register are 0. Reset mid-run aborts immediately with no clr_valid for a partially copied block.
- IDLE:
  - On the cycle after start goes 0->1: snap <= d_table, blk_count <= 0, busy <= 1, go to SCAN.
  - start held high does not retrigger.
  - A start edge while busy is ignored.
- SCAN:
  - If snap == 0, go to FIN.
  - Otherwise cur <= index of the lowest set bit (combinational priority encode), w <= 0, go to RD.
- RD: one-cycle dmem_rd_en=1 with dmem_addr = DMEM_BASE + cur*BLK_SIZE + 2*w; go to CAP.
- CAP: latch dmem_rd_data into nvm_wr_data; nvm_addr = NVM_BASE + cur*BLK_SIZE + 2*w; raise nvm_wr_req; go to WR.
- WR:
  - nvm_wr_req, nvm_addr and nvm_wr_data stay stable until nvm_wr_ack is sampled high. No timeout.
  - On ack, drop the request the next cycle.
  - If w == WPB-1, go to CLR; otherwise w <= w+1 and go to RD.
  - An ack in the same cycle the request rises counts. An ack outside WR is ignored.
- CLR: clr_valid=1, clr_idx=cur for exactly one cycle; snap[cur] <= 0; blk_count <= blk_count+1; go to SCAN.
- FIN: done=1 for one cycle, busy <= 0, go to IDLE. blk_count holds until the next start.
- Timing per block: 3 cycles per word plus NVM wait cycles, plus 1 CLR cycle and 1 SCAN cycle.
- Snapshot rules: bits set in d_table after the snapshot are not copied in this run. Blocks cleared by the tracker mid-run are still copied.
- Address arithmetic is 16-bit modulo; NVM_BASE + DMEM_SIZE - 1 must not exceed 16'hFFFF (parameter check).
- blk_count is wide enough for TOTAL_BLOCKS with no wrap.

Decomposition:
- Shared include dica_defines: state encodings (IDLE, SCAN, RD, CAP, WR, CLR, FIN), the DMEM_BASE/NVM_BASE/BLK_SIZE defaults, and the block-to-address offset macro. The tracker uses the same constants.
- One sub-module, dica_first_set: a parameterised lowest-set-bit priority encoder with inputs vec[TOTAL_BLOCKS] and outputs idx[IDX_W] and any.

Test Plan:
- d_table=16'h0000, start pulse -> busy for 2 cycles (SCAN, FIN); done pulse; blk_count=0; no dmem_rd_en, nvm_wr_req or clr_valid.
- d_table=16'h0001, nvm_wr_ack tied 1 -> 32 writes with nvm_addr 16'hA000..16'hA03E carrying the DMEM 16'h0200..16'h023E data; one clr_valid with clr_idx=0; done; blk_count=1.
- d_table=16'h8004 -> blocks 2 then 15 copied, in that order; first nvm_addr=16'hA080, last=16'hA3FE; clr_idx sequence 2, 15; blk_count=2.
- Block 3 dirty, ack delayed 5 cycles on word 7 -> nvm_addr and nvm_wr_data stable for all 5 wait cycles; no extra dmem_rd_en; total writes=32.
- reset_n=0 during word 10 of block 1 -> next cycle all outputs 0 and state IDLE; no clr_valid for block 1; a later start restarts from the fresh d_table.
- start held high through done, then d_table changes -> no second run until start falls and rises again.
